reorder_ring: RTL and testbench
===============================

REORDER_RING -- requirements
Module: reorder_ring

Interface
REQ-001 Parameter DEPTH, 8, entry count; power of two, >=4.
REQ-002 Parameter XLEN, 32, data/PC width.
REQ-003 Parameter NWB, 2, writeback channel count, >=1; TAGW = log2(DEPTH) is derived and not overridable.
REQ-004 clk  in  1  clock; all state changes on posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 alloc_valid  in  1  dispatch requests an entry.
REQ-007 alloc_ready  out  1  combinational, count < DEPTH.
REQ-008 alloc_kind  in  2  00 ALU/load, 01 store, 10 branch, 11 jump.
REQ-009 alloc_rd  in  5  destination register.
REQ-010 alloc_pc  in  XLEN  instruction PC.
REQ-011 alloc_tag  out  TAGW  combinational, equals tail.
REQ-012 wb_valid  in  NWB  per-channel writeback strobe.
REQ-013 wb_tag  in  NWB*TAGW  packed tags; channel k occupies bits [k*TAGW +: TAGW].
REQ-014 wb_value  in  NWB*XLEN  packed result values.
REQ-015 wb_redirect  in  NWB  1 = mispredict or jump; flush required.
REQ-016 wb_target  in  NWB*XLEN  packed redirect PCs.
REQ-017 commit_valid, commit_store  out  1 each  registered one-cycle pulses.
REQ-018 commit_rd  out  5; commit_value  out  XLEN; commit_tag  out  TAGW; all registered.
REQ-019 flush  out  1; flush_pc  out  XLEN; both registered.
REQ-020 count  out  TAGW+1; empty  out  1 (count==0).

Function
REQ-021 Allocation: alloc_valid && alloc_ready at an edge writes the tail entry (busy=1, done=0, kind, rd, pc) and sets tail = (tail+1) mod DEPTH.
REQ-022 Full is count==DEPTH, and alloc_ready=0 whenever full, even in a cycle where a commit occurs.
REQ-023 count: next = count + alloc_fire - commit_fire; simultaneous alloc and commit leaves count unchanged.
REQ-024 Writeback on channel k to a busy entry sets done=1 and latches value, redirect and target at the edge.
REQ-025 Writeback to a non-busy entry has no effect.
REQ-026 When several channels write the same tag in one cycle, the highest channel index wins.
REQ-027 Commit: at each edge where the head entry is busy and done, outputs load from that entry, commit_valid=1, the entry is cleared, and head increments mod DEPTH.
REQ-028 In any cycle with no commit, commit_valid=0 and commit_store=0.
REQ-029 Minimum latency: writeback accepted at edge N -> commit_valid high after edge N+1; allocation at edge N -> writeback accepted no earlier than edge N+1.
REQ-030 commit_rd = rd for kind 00/11, else 0; commit_store = 1 only for kind 01.
REQ-031 commit_value = pc+4 (mod 2^XLEN) for kind 11, the latched value for kind 00, and 0 for kinds 01/10.
REQ-032 Flush: committing an entry with redirect=1 sets flush=1 and flush_pc=target on the same edge as commit_valid.
REQ-033 On that edge all entries become non-busy and head=tail=count=0; any allocation and writebacks presented in that cycle are discarded.
REQ-034 flush is a one-cycle pulse; flush_pc holds its value until the next flush or reset.
REQ-035 Commit throughput is at most one entry per cycle, strictly in allocation order; head and tail wrap from DEPTH-1 to 0.

Reset
REQ-036 rst=0 at an edge overrides all other activity that cycle.
REQ-037 Reset clears head, tail, count and all busy/done bits, and clears commit_valid, commit_store, commit_rd, commit_value, commit_tag, flush and flush_pc to 0.
REQ-038 After reset, alloc_ready=1, empty=1 and alloc_tag=0; reset asserted mid-flush or while full yields the same state.

Verification
REQ-039 Fill: DEPTH=8, 8 back-to-back allocs with no writeback -> count=8, alloc_ready=0; a ninth alloc_valid leaves tail unchanged.
REQ-040 Out-of-order writeback: alloc tags 0,1,2 (kind 00, rd 5,6,7); writeback 2 then 1 then 0 -> commits in tag order 0,1,2 on three consecutive cycles with the correct rd/value.
REQ-041 Same-tag collision: ch0 and ch1 both write tag 3 with values 0xAA and 0xBB in one cycle -> commit_value=0xBB.
REQ-042 Jump flush: jump at pc 0x100, tag 0, rd 1, redirect=1, target 0x200, with tag 1 allocated behind it -> commit_rd=1, commit_value=0x104, flush=1, flush_pc=0x200; then count=0 and tag 1 is never committed.
REQ-043 Wrap: 20 alloc/commit pairs at DEPTH=8 -> commit_tag sequence 0..7,0..7,0..3 with no lost entries.
REQ-044 Reset while full with pending writebacks -> next cycle count=0, commit_valid=0, alloc_tag=0.

Source files
------------

// File: rtl/reorder_ring.sv
// rtl/reorder_ring.sv - in-order commit ring for out-of-order writeback with flush on redirect
module reorder_ring #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int NWB   = 2,
  localparam int TAGW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [1:0]           alloc_kind,
  input  logic [4:0]           alloc_rd,
  input  logic [XLEN-1:0]      alloc_pc,
  output logic [TAGW-1:0]      alloc_tag,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*TAGW-1:0]  wb_tag,
  input  logic [NWB*XLEN-1:0]  wb_value,
  input  logic [NWB-1:0]       wb_redirect,
  input  logic [NWB*XLEN-1:0]  wb_target,
  output logic                 commit_valid,
  output logic                 commit_store,
  output logic [4:0]           commit_rd,
  output logic [XLEN-1:0]      commit_value,
  output logic [TAGW-1:0]      commit_tag,
  output logic                 flush,
  output logic [XLEN-1:0]      flush_pc,
  output logic [TAGW:0]        count,
  output logic                 empty
);

  localparam logic [TAGW:0] FULL_CNT = (TAGW+1)'(DEPTH);

  logic [TAGW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAGW:0]    count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d, redir_q, redir_d;
  logic [1:0]       kind_q   [DEPTH];
  logic [1:0]       kind_d   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       rd_d     [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [XLEN-1:0]  pc_d     [DEPTH];
  logic [XLEN-1:0]  value_q  [DEPTH];
  logic [XLEN-1:0]  value_d  [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [XLEN-1:0]  target_d [DEPTH];

  logic             commit_valid_q, commit_valid_d, commit_store_q, commit_store_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [XLEN-1:0]  commit_value_q, commit_value_d;
  logic [TAGW-1:0]  commit_tag_q, commit_tag_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

  logic             alloc_fire, commit_fire, do_flush;
  logic [1:0]       head_kind;
  logic [TAGW-1:0]  wtag;

  assign alloc_ready  = (count_q < FULL_CNT);
  assign alloc_tag    = tail_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign commit_valid = commit_valid_q;
  assign commit_store = commit_store_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

  always_comb begin
    head_d = head_q;   tail_d = tail_q;   count_d = count_q;
    busy_d = busy_q;   done_d = done_q;   redir_d = redir_q;
    kind_d = kind_q;   rd_d = rd_q;       pc_d = pc_q;
    value_d = value_q; target_d = target_q;
    commit_valid_d = 1'b0;
    commit_store_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_tag_d   = commit_tag_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;
    wtag           = '0;

    head_kind   = kind_q[head_q];
    alloc_fire  = alloc_valid && alloc_ready;
    commit_fire = busy_q[head_q] && done_q[head_q];
    do_flush    = commit_fire && redir_q[head_q];

    if (commit_fire) begin
      commit_valid_d = 1'b1;
      commit_store_d = (head_kind == 2'b01);
      commit_tag_d   = head_q;
      commit_rd_d    = (head_kind == 2'b00 || head_kind == 2'b11) ? rd_q[head_q] : 5'd0;
      case (head_kind)
        2'b11:   commit_value_d = pc_q[head_q] + XLEN'(4);
        2'b00:   commit_value_d = value_q[head_q];
        default: commit_value_d = '0;
      endcase
    end

    // A redirecting commit squashes everything younger, including this cycle's traffic.
    if (do_flush) begin
      flush_d    = 1'b1;
      flush_pc_d = target_q[head_q];
      busy_d     = '0;
      done_d     = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      // Ascending loop: a higher channel hitting the same tag overwrites a lower one.
      for (int k = 0; k < NWB; k++) begin
        wtag = wb_tag[k*TAGW +: TAGW];
        if (wb_valid[k] && busy_q[wtag]) begin
          done_d[wtag]   = 1'b1;
          value_d[wtag]  = wb_value[k*XLEN +: XLEN];
          redir_d[wtag]  = wb_redirect[k];
          target_d[wtag] = wb_target[k*XLEN +: XLEN];
        end
      end
      if (commit_fire) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + 1'b1;
      end
      if (alloc_fire) begin
        busy_d[tail_q]  = 1'b1;
        done_d[tail_q]  = 1'b0;
        redir_d[tail_q] = 1'b0;
        kind_d[tail_q]  = alloc_kind;
        rd_d[tail_q]    = alloc_rd;
        pc_d[tail_q]    = alloc_pc;
        tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + {{TAGW{1'b0}}, alloc_fire} - {{TAGW{1'b0}}, commit_fire};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_store_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      commit_valid_q <= commit_valid_d;
      commit_store_q <= commit_store_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_tag_q   <= commit_tag_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    redir_q  <= redir_d;
    kind_q   <= kind_d;
    rd_q     <= rd_d;
    pc_q     <= pc_d;
    value_q  <= value_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_reorder_ring.sv
// tb/tb_reorder_ring.sv - randomized and directed bench for reorder_ring against a queue model
module tb_reorder_ring;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int NWB   = 2;
  localparam int TAGW  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                alloc_valid;
  logic                alloc_ready;
  logic [1:0]          alloc_kind;
  logic [4:0]          alloc_rd;
  logic [XLEN-1:0]     alloc_pc;
  logic [TAGW-1:0]     alloc_tag;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*TAGW-1:0] wb_tag;
  logic [NWB*XLEN-1:0] wb_value;
  logic [NWB-1:0]      wb_redirect;
  logic [NWB*XLEN-1:0] wb_target;
  logic                commit_valid, commit_store;
  logic [4:0]          commit_rd;
  logic [XLEN-1:0]     commit_value;
  logic [TAGW-1:0]     commit_tag;
  logic                flush;
  logic [XLEN-1:0]     flush_pc;
  logic [TAGW:0]       count;
  logic                empty;

  reorder_ring #(.DEPTH(DEPTH), .XLEN(XLEN), .NWB(NWB)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
    .alloc_rd(alloc_rd), .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_redirect(wb_redirect), .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_store(commit_store), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .flush(flush), .flush_pc(flush_pc), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [1:0]      kind;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    bit              done;
    logic [XLEN-1:0] val;
    bit              redir;
    logic [XLEN-1:0] tgt;
  } ent_t;

  ent_t            rob[$];
  int              m_tail;
  bit              e_cv, e_cs, e_fl;
  logic [4:0]      e_rd;
  logic [XLEN-1:0] e_val, e_fpc;
  logic [TAGW-1:0] e_ctag;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the ring is a FIFO of in-flight instructions; only what is in it can be written back.
  task automatic model_step();
    ent_t e;
    bit   cm;
    int   pre;
    e_cv = 0; e_cs = 0; e_fl = 0;
    if (!rst) begin
      rob.delete(); m_tail = 0;
      e_rd = '0; e_val = '0; e_ctag = '0; e_fpc = '0;
      return;
    end
    pre = rob.size();
    cm  = (pre > 0) && rob[0].done;
    if (cm) begin
      e      = rob[0];
      e_cv   = 1;
      e_ctag = e.tag;
      e_cs   = (e.kind == 2'b01);
      e_rd   = (e.kind == 2'b00 || e.kind == 2'b11) ? e.rd : 5'd0;
      e_val  = (e.kind == 2'b11) ? e.pc + 32'd4 : (e.kind == 2'b00) ? e.val : 32'd0;
      if (e.redir) begin
        e_fl = 1; e_fpc = e.tgt;
        rob.delete(); m_tail = 0;
        return;
      end
    end
    for (int k = 0; k < NWB; k++)
      if (wb_valid[k])
        foreach (rob[i])
          if (rob[i].tag == wb_tag[k*TAGW +: TAGW]) begin
            rob[i].done  = 1;
            rob[i].val   = wb_value[k*XLEN +: XLEN];
            rob[i].redir = wb_redirect[k];
            rob[i].tgt   = wb_target[k*XLEN +: XLEN];
          end
    if (cm) void'(rob.pop_front());
    if (alloc_valid && pre < DEPTH) begin
      e = '{tag: TAGW'(m_tail), kind: alloc_kind, rd: alloc_rd, pc: alloc_pc,
            done: 0, val: '0, redir: 0, tgt: '0};
      rob.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic check_all(input bit after_rst);
    chk("alloc_ready", alloc_ready, rob.size() < DEPTH);
    chk("alloc_tag", alloc_tag, m_tail);
    chk("count", count, rob.size());
    chk("empty", empty, rob.size() == 0);
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_store", commit_store, e_cs);
    chk("flush", flush, e_fl);
    chk("flush_pc", flush_pc, e_fpc);
    if (e_cv || after_rst) begin
      chk("commit_rd", commit_rd, e_rd);
      chk("commit_value", commit_value, e_val);
      chk("commit_tag", commit_tag, e_ctag);
    end
  endtask

  task automatic cyc();
    bit was_rst;
    was_rst = !rst;
    model_step();
    @(posedge clk); #1;
    check_all(was_rst);
  endtask

  task automatic idle_in();
    alloc_valid = 0; wb_valid = '0; wb_redirect = '0;
  endtask

  task automatic set_alloc(input logic [1:0] k, input logic [4:0] rd, input logic [XLEN-1:0] pc);
    alloc_valid = 1; alloc_kind = k; alloc_rd = rd; alloc_pc = pc;
  endtask

  task automatic set_wb(input int ch, input int t, input logic [XLEN-1:0] v,
                        input bit rd_i, input logic [XLEN-1:0] tgt);
    wb_valid[ch] = 1'b1;
    wb_tag[ch*TAGW +: TAGW] = TAGW'(t);
    wb_value[ch*XLEN +: XLEN] = v;
    wb_redirect[ch] = rd_i;
    wb_target[ch*XLEN +: XLEN] = tgt;
  endtask

  task automatic do_reset();
    idle_in(); rst = 0; cyc(); rst = 1;
  endtask

  initial begin
    logic [TAGW-1:0] ctags[$];
    bit              seen;
    int              idx;
    rst = 1; alloc_kind = '0; alloc_rd = '0; alloc_pc = '0;
    wb_tag = '0; wb_value = '0; wb_target = '0;
    idle_in();
    rob.delete(); m_tail = 0;
    @(negedge clk);

    do_reset();
    chk("rst_ready", alloc_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_tag", alloc_tag, 0);

    for (int i = 0; i < DEPTH; i++) begin set_alloc(2'b00, 5'(i), 32'h40 + 32'(i*4)); cyc(); end
    chk("fill_count", count, DEPTH);
    chk("fill_ready", alloc_ready, 0);
    set_alloc(2'b00, 5'd31, 32'h999); cyc();
    chk("fill_tail_hold", alloc_tag, 0);
    chk("fill_count_hold", count, DEPTH);
    idle_in();
    for (int t = 0; t < DEPTH; t += 2) begin
      idle_in(); set_wb(0, t, 32'h500 + t, 0, 0); set_wb(1, t + 1, 32'h500 + t + 1, 0, 0); cyc();
    end
    idle_in();
    for (int i = 0; i < 10; i++) cyc();
    chk("drain_empty", empty, 1);

    do_reset();
    set_alloc(2'b00, 5'd5, 32'h10); cyc();
    set_alloc(2'b00, 5'd6, 32'h14); cyc();
    set_alloc(2'b00, 5'd7, 32'h18); cyc();
    idle_in(); set_wb(0, 2, 32'h1002, 0, 0); cyc();
    idle_in(); set_wb(1, 1, 32'h1001, 0, 0); cyc();
    idle_in(); set_wb(0, 0, 32'h1000, 0, 0); cyc();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ooo_valid", commit_valid, 1);
      chk("ooo_tag", commit_tag, i);
      chk("ooo_rd", commit_rd, 5 + i);
      chk("ooo_value", commit_value, 32'h1000 + i);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin set_alloc(2'b00, 5'(i + 1), 32'(i * 4)); cyc(); end
    idle_in(); set_wb(0, 3, 32'hAA, 0, 0); set_wb(1, 3, 32'hBB, 0, 0); cyc();
    idle_in(); set_wb(0, 0, 32'h1, 0, 0); set_wb(1, 1, 32'h2, 0, 0); cyc();
    idle_in(); set_wb(0, 2, 32'h3, 0, 0); cyc();
    idle_in();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (commit_valid && commit_tag == 3) begin seen = 1; chk("collide_value", commit_value, 32'hBB); end
    end
    chk("collide_seen", seen, 1);

    do_reset();
    set_alloc(2'b11, 5'd1, 32'h100); cyc();
    set_alloc(2'b00, 5'd9, 32'h104); set_wb(0, 0, 32'h0, 1, 32'h200); cyc();
    idle_in(); cyc();
    chk("jmp_valid", commit_valid, 1);
    chk("jmp_rd", commit_rd, 1);
    chk("jmp_value", commit_value, 32'h104);
    chk("jmp_flush", flush, 1);
    chk("jmp_flush_pc", flush_pc, 32'h200);
    chk("jmp_count", count, 0);
    set_wb(0, 1, 32'h77, 0, 0); cyc();
    idle_in();
    seen = 0;
    for (int i = 0; i < 5; i++) begin cyc(); if (commit_valid) seen = 1; end
    chk("jmp_no_commit", seen, 0);
    chk("jmp_pc_hold", flush_pc, 32'h200);

    do_reset();
    ctags.delete();
    for (int i = 0; i <= 20; i++) begin
      idle_in();
      if (i < 20) set_alloc(2'b00, 5'(i), 32'(i * 4));
      if (i > 0) set_wb(0, (i - 1) % DEPTH, 32'(i), 0, 0);
      cyc();
      if (commit_valid) ctags.push_back(commit_tag);
    end
    idle_in();
    for (int i = 0; i < 4; i++) begin cyc(); if (commit_valid) ctags.push_back(commit_tag); end
    chk("wrap_n", ctags.size(), 20);
    for (int j = 0; j < 20; j++)
      chk("wrap_tag", (j < ctags.size()) ? 64'(ctags[j]) : 64'hdead, j % DEPTH);

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin set_alloc(2'b01, 5'(i), 32'(i)); cyc(); end
    idle_in(); set_wb(0, 0, 32'h5, 0, 0); set_wb(1, 1, 32'h6, 1, 32'h80);
    rst = 0; cyc(); rst = 1; idle_in();
    chk("rstfull_count", count, 0);
    chk("rstfull_cv", commit_valid, 0);
    chk("rstfull_tag", alloc_tag, 0);

    for (int n = 0; n < 1500; n++) begin
      idle_in();
      rst = ($urandom_range(199) != 0);
      if ($urandom_range(2) != 0)
        set_alloc(2'($urandom_range(3)), 5'($urandom_range(31)), $urandom);
      for (int k = 0; k < NWB; k++)
        if ($urandom_range(2) == 0) begin
          idx = (rob.size() > 0 && $urandom_range(4) != 0)
                ? int'(rob[$urandom_range(rob.size() - 1)].tag) : int'($urandom_range(DEPTH - 1));
          set_wb(k, idx, $urandom, ($urandom_range(15) == 0), $urandom);
        end
      cyc();
    end
    rst = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
